// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - requester and data-memory signal bundle for dmem_arbiter
// Lock inputs exist only when DMEM_ARB_LOCK_EN is defined.
interface dmem_arbiter_if #(
  parameter int DATA_BIT_WIDTH = 32,
  parameter int DMEMADDRBITS   = 13
);
  logic                      reqA;
  logic                      weA;
  logic [DMEMADDRBITS-1:0]   addrA;
  logic [DATA_BIT_WIDTH-1:0] wdataA;
  logic                      ackA;
  logic [DATA_BIT_WIDTH-1:0] rdataA;
  logic                      reqB;
  logic                      weB;
  logic [DMEMADDRBITS-1:0]   addrB;
  logic [DATA_BIT_WIDTH-1:0] wdataB;
  logic                      ackB;
  logic [DATA_BIT_WIDTH-1:0] rdataB;
  logic                      mem_wr;
  logic [DMEMADDRBITS-1:0]   mem_addr;
  logic [DATA_BIT_WIDTH-1:0] mem_dataIn;
  logic [DATA_BIT_WIDTH-1:0] mem_dataOut;
  logic [1:0]                grant;
  logic                      busy;
`ifdef DMEM_ARB_LOCK_EN
  logic                      lockA;
  logic                      lockB;

  modport slave (
    input  reqA, weA, addrA, wdataA, lockA, reqB, weB, addrB, wdataB, lockB, mem_dataOut,
    output ackA, rdataA, ackB, rdataB, mem_wr, mem_addr, mem_dataIn, grant, busy
  );
  modport master (
    output reqA, weA, addrA, wdataA, lockA, reqB, weB, addrB, wdataB, lockB, mem_dataOut,
    input  ackA, rdataA, ackB, rdataB, mem_wr, mem_addr, mem_dataIn, grant, busy
  );
`else
  modport slave (
    input  reqA, weA, addrA, wdataA, reqB, weB, addrB, wdataB, mem_dataOut,
    output ackA, rdataA, ackB, rdataB, mem_wr, mem_addr, mem_dataIn, grant, busy
  );
  modport master (
    output reqA, weA, addrA, wdataA, reqB, weB, addrB, wdataB, mem_dataOut,
    input  ackA, rdataA, ackB, rdataB, mem_wr, mem_addr, mem_dataIn, grant, busy
  );
`endif
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin arbiter sharing one data-memory port between A and B
// Ownership lock (lockA/lockB) is compiled in with `define DMEM_ARB_LOCK_EN.
module dmem_arbiter #(
  parameter int DATA_BIT_WIDTH = 32,
  parameter int DMEMADDRBITS   = 13
) (
  input logic           clk,
  input logic           reset,
  dmem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t                    state;
  logic                      last_grant;
  logic                      owner_b;
  logic                      we_q;
  logic                      wr_q;
  logic [DMEMADDRBITS-1:0]   addr_q;
  logic [DATA_BIT_WIDTH-1:0] data_q;
  logic [DATA_BIT_WIDTH-1:0] rdata_a_q;
  logic [DATA_BIT_WIDTH-1:0] rdata_b_q;
  logic [1:0]                grant_q;
  logic                      ack_a_q;
  logic                      ack_b_q;
  logic                      req_a;
  logic                      req_b;
  logic                      pick_b;

`ifdef DMEM_ARB_LOCK_EN
  logic lock_hold;

  // A locked owner that still requests masks the other requester
  always_comb begin
    req_a = bus.reqA & ~(lock_hold & owner_b & bus.reqB);
    req_b = bus.reqB & ~(lock_hold & ~owner_b & bus.reqA);
  end
`else
  always_comb begin
    req_a = bus.reqA;
    req_b = bus.reqB;
  end
`endif

  // last_grant: 0 = A, 1 = B; a tie goes to the one not granted last
  always_comb begin
    pick_b = req_b & (~req_a | ~last_grant);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      owner_b    <= 1'b0;
      we_q       <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      rdata_a_q  <= '0;
      rdata_b_q  <= '0;
      grant_q    <= 2'b00;
      ack_a_q    <= 1'b0;
      ack_b_q    <= 1'b0;
`ifdef DMEM_ARB_LOCK_EN
      lock_hold  <= 1'b0;
`endif
    end else begin
      ack_a_q <= 1'b0;
      ack_b_q <= 1'b0;
      case (state)
        IDLE: begin
`ifdef DMEM_ARB_LOCK_EN
          if (lock_hold && !(owner_b ? bus.reqB : bus.reqA)) begin
            lock_hold <= 1'b0;
          end
`endif
          if (req_a || req_b) begin
            owner_b <= pick_b;
            we_q    <= pick_b ? bus.weB    : bus.weA;
            wr_q    <= pick_b ? bus.weB    : bus.weA;
            addr_q  <= pick_b ? bus.addrB  : bus.addrA;
            data_q  <= pick_b ? bus.wdataB : bus.wdataA;
            grant_q <= pick_b ? 2'b10      : 2'b01;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          wr_q  <= 1'b0;
          state <= CAPTURE;
        end
        CAPTURE: begin
          if (!we_q) begin
            if (owner_b) rdata_b_q <= bus.mem_dataOut;
            else         rdata_a_q <= bus.mem_dataOut;
          end
          ack_a_q <= ~owner_b;
          ack_b_q <= owner_b;
          state   <= DONE;
        end
        DONE: begin
`ifdef DMEM_ARB_LOCK_EN
          if (owner_b ? bus.lockB : bus.lockA) begin
            lock_hold <= 1'b1;
          end else begin
            lock_hold  <= 1'b0;
            last_grant <= owner_b;
          end
`else
          last_grant <= owner_b;
`endif
          grant_q <= 2'b00;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Reset gates the strobe directly so a write caught in ISSUE never reaches memory
  assign bus.mem_wr     = wr_q & ~reset;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_dataIn = data_q;
  assign bus.ackA       = ack_a_q;
  assign bus.ackB       = ack_b_q;
  assign bus.rdataA     = rdata_a_q;
  assign bus.rdataB     = rdata_b_q;
  assign bus.grant      = grant_q;
  assign bus.busy       = (state != IDLE);
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter
module tb_dmem_arbiter;
  localparam int DW = 32;
  localparam int AW = 13;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.DATA_BIT_WIDTH(DW), .DMEMADDRBITS(AW)) bus ();

  dmem_arbiter #(.DATA_BIT_WIDTH(DW), .DMEMADDRBITS(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Synchronous memory with one-cycle read latency plus a bench preload path
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic          pre_we   = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [DW-1:0] pre_data = '0;
  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (bus.mem_wr) mem[bus.mem_addr] <= bus.mem_dataIn;
    bus.mem_dataOut <= mem[bus.mem_addr];
  end

  int checks   = 0;
  int failures = 0;
  logic [31:0] ha, hb, hg, eg, rda, rdb;
  logic        any_wr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pre_addr = a;
    pre_data = d;
    pre_we   = 1'b1;
    tick();
    pre_we   = 1'b0;
  endtask

  task automatic clear_reqs();
    bus.reqA = 1'b0; bus.weA = 1'b0; bus.addrA = '0; bus.wdataA = '0;
    bus.reqB = 1'b0; bus.weB = 1'b0; bus.addrB = '0; bus.wdataB = '0;
`ifdef DMEM_ARB_LOCK_EN
    bus.lockA = 1'b0; bus.lockB = 1'b0;
`endif
  endtask

  // Runs cycles 1..last after requests are raised in cycle 0, logging acks and grant
  task automatic run_log(input int last, input int lock_drop);
    ha = '0; hb = '0; hg = '0; rda = '0; rdb = '0;
    hg[1:0] = bus.grant;
    for (int c = 1; c <= last; c++) begin
      tick();
      ha[c] = bus.ackA;
      hb[c] = bus.ackB;
      if (c < 16) hg[2*c +: 2] = bus.grant;
      if (bus.ackA) rda = bus.rdataA;
      if (bus.ackB) rdb = bus.rdataB;
`ifdef DMEM_ARB_LOCK_EN
      if (c == lock_drop) bus.lockA = 1'b0;
`endif
      if (c == last) begin
        bus.reqA = 1'b0;
        bus.reqB = 1'b0;
      end
    end
  endtask

  initial begin
    clear_reqs();
    reset = 1'b1;
    preload(13'h020, 32'h5A5A0000);
    preload(13'h030, 32'h11112222);
    preload(13'h040, 32'h33334444);
    reset = 1'b0;

    check("rst_grant", {30'd0, bus.grant}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_acks", {30'd0, bus.ackA, bus.ackB}, 32'd0);
    check("rst_mem_wr", {31'd0, bus.mem_wr}, 32'd0);
    check("rst_rdataA", bus.rdataA, 32'd0);
    check("rst_rdataB", bus.rdataB, 32'd0);
    check("rst_mem_addr", {19'd0, bus.mem_addr}, 32'd0);

    // A write
    bus.reqA = 1'b1; bus.weA = 1'b1; bus.addrA = 13'h010; bus.wdataA = 32'hDEADBEEF;
    tick();
    check("wrA_c1_wr", {31'd0, bus.mem_wr}, 32'd1);
    check("wrA_c1_addr", {19'd0, bus.mem_addr}, 32'h010);
    check("wrA_c1_data", bus.mem_dataIn, 32'hDEADBEEF);
    check("wrA_c1_grant", {30'd0, bus.grant}, 32'd1);
    check("wrA_c1_busy", {31'd0, bus.busy}, 32'd1);
    tick();
    check("wrA_c2_wr", {31'd0, bus.mem_wr}, 32'd0);
    check("wrA_c2_ack", {31'd0, bus.ackA}, 32'd0);
    tick();
    check("wrA_c3_ackA", {31'd0, bus.ackA}, 32'd1);
    check("wrA_c3_ackB", {31'd0, bus.ackB}, 32'd0);
    bus.reqA = 1'b0; bus.weA = 1'b0;
    tick();
    check("wrA_c4_ackA", {31'd0, bus.ackA}, 32'd0);
    check("wrA_c4_grant", {30'd0, bus.grant}, 32'd0);
    check("wrA_c4_busy", {31'd0, bus.busy}, 32'd0);

    // A read-back
    bus.reqA = 1'b1; bus.weA = 1'b0; bus.addrA = 13'h010;
    any_wr = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      tick();
      any_wr = any_wr | bus.mem_wr;
    end
    check("rdA_ack", {31'd0, bus.ackA}, 32'd1);
    check("rdA_data", bus.rdataA, 32'hDEADBEEF);
    check("rdA_no_wr", {31'd0, any_wr}, 32'd0);
    bus.reqA = 1'b0;
    tick();

    // B write then read at the top address
    bus.reqB = 1'b1; bus.weB = 1'b1; bus.addrB = 13'h1FFF; bus.wdataB = 32'hA5A5A5A5;
    tick();
    check("wrB_c1_wr", {31'd0, bus.mem_wr}, 32'd1);
    check("wrB_c1_addr", {19'd0, bus.mem_addr}, 32'h1FFF);
    check("wrB_c1_grant", {30'd0, bus.grant}, 32'd2);
    tick();
    tick();
    check("wrB_c3_acks", {30'd0, bus.ackA, bus.ackB}, 32'd1);
    bus.weB = 1'b0;
    repeat (4) tick();
    check("rdB_ack", {31'd0, bus.ackB}, 32'd1);
    check("rdB_data", bus.rdataB, 32'hA5A5A5A5);
    check("rdB_rdataA_kept", bus.rdataA, 32'hDEADBEEF);
    bus.reqB = 1'b0;
    tick();

    // Simultaneous reads straight out of reset alternate A, B, A
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    bus.reqA = 1'b1; bus.weA = 1'b0; bus.addrA = 13'h030;
    bus.reqB = 1'b1; bus.weB = 1'b0; bus.addrB = 13'h040;
    run_log(11, 0);
    eg = '0;
    for (int c = 0; c <= 11; c++) begin
      if (c % 4 != 0) eg[2*c +: 2] = ((c / 4) % 2 == 0) ? 2'b01 : 2'b10;
    end
    check("rr_ackA_cycles", ha, 32'h0000_0808);
    check("rr_ackB_cycles", hb, 32'h0000_0080);
    check("rr_grant_trace", hg, eg);
    check("rr_rdataA", rda, 32'h11112222);
    check("rr_rdataB", rdb, 32'h33334444);
    tick();
    tick();

    // Reset landing on the ISSUE cycle of a write
    bus.reqA = 1'b1; bus.weA = 1'b1; bus.addrA = 13'h020; bus.wdataA = 32'hCAFEF00D;
    tick();
    reset = 1'b1;
    #1;
    check("rstwr_mem_wr", {31'd0, bus.mem_wr}, 32'd0);
    bus.reqA = 1'b0; bus.weA = 1'b0;
    tick();
    reset = 1'b0;
    check("rstwr_busy", {31'd0, bus.busy}, 32'd0);
    check("rstwr_grant", {30'd0, bus.grant}, 32'd0);
    ha = '0;
    for (int c = 0; c < 4; c++) begin
      tick();
      ha[0] = ha[0] | bus.ackA;
    end
    check("rstwr_no_ack", ha, 32'd0);
    bus.reqA = 1'b1; bus.weA = 1'b0; bus.addrA = 13'h020;
    repeat (3) tick();
    check("rstwr_readback_ack", {31'd0, bus.ackA}, 32'd1);
    check("rstwr_readback", bus.rdataA, 32'h5A5A0000);
    bus.reqA = 1'b0;
    tick();

`ifdef DMEM_ARB_LOCK_EN
    // A keeps ownership across three transactions, then B is served
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    bus.reqA = 1'b1; bus.weA = 1'b0; bus.addrA = 13'h030; bus.lockA = 1'b1;
    bus.reqB = 1'b1; bus.weB = 1'b0; bus.addrB = 13'h040;
    run_log(15, 8);
    check("lock_ackA_cycles", ha, 32'h0000_0888);
    check("lock_ackB_cycles", hb, 32'h0000_8000);
    check("lock_rdataB", rdb, 32'h33334444);
    tick();
    tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
